// File: rtl/divisor_algoritmico.sv
`default_nettype none
// ============================================================================
// Module   : divisor_algoritmico
// Brief    : Sequential signed restoring divider (truncating, C-style / and %).
//            Optional macro DIV_ZERO_FAST_EN: DEN=0 skips the shift-subtract loop.
// Revision : 1.0 - initial release
// ============================================================================
module divisor_algoritmico #(
  parameter int tamanyo = 32
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               START,
  input  logic [tamanyo-1:0] NUM,
  input  logic [tamanyo-1:0] DEN,
  output logic [tamanyo-1:0] COC,
  output logic [tamanyo-1:0] RES,
  output logic               DONE
);

  localparam int              c_CW       = $clog2(tamanyo + 1);
  localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(tamanyo);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOOP = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CW-1:0]    r_cnt;
  logic [tamanyo-1:0] r_rem;
  logic [tamanyo-1:0] r_quo;
  logic [tamanyo-1:0] r_den;
  logic               r_snum;
  logic               r_sq;

  logic               w_load;
  logic               w_step;
  logic               w_fix;
  logic               w_fast_zero;

  logic [tamanyo-1:0] w_num_mag;
  logic [tamanyo-1:0] w_den_mag;
  logic [tamanyo:0]   w_trial;

  // Magnitudes are unsigned, so the most negative value maps to 2^(tamanyo-1).
  assign w_num_mag = NUM[tamanyo-1] ? -NUM : NUM;
  assign w_den_mag = DEN[tamanyo-1] ? -DEN : DEN;

  // The shifted partial remainder always fits tamanyo bits because rem < den.
  assign w_trial = {r_rem, r_quo[tamanyo-1]} - {1'b0, r_den};

`ifdef DIV_ZERO_FAST_EN
  assign w_fast_zero = (DEN == '0);
`else
  assign w_fast_zero = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (START) w_state_nxt = w_fast_zero ? c_FIX : c_LOOP;
      c_LOOP:  if (r_cnt == c_CNT_LAST) w_state_nxt = c_FIX;
      c_FIX:   w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      c_IDLE:  w_load = START;
      c_LOOP:  w_step = 1'b1;
      c_FIX:   w_fix  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_den  <= '0;
      r_snum <= 1'b0;
      r_sq   <= 1'b0;
      COC    <= '0;
      RES    <= '0;
      DONE   <= 1'b0;
    end else begin
      DONE <= w_fix;
      if (w_load) begin
        r_den  <= w_den_mag;
        r_snum <= NUM[tamanyo-1];
        r_sq   <= NUM[tamanyo-1] ^ DEN[tamanyo-1];
        r_cnt  <= c_CNT_INIT;
        if (w_fast_zero) begin
          // Preload what the full loop would produce for a zero divisor.
          r_rem <= w_num_mag;
          r_quo <= '1;
        end else begin
          r_rem <= '0;
          r_quo <= w_num_mag;
        end
      end
      if (w_step) begin
        r_cnt <= r_cnt - 1'b1;
        r_quo <= {r_quo[tamanyo-2:0], ~w_trial[tamanyo]};
        if (w_trial[tamanyo]) begin
          r_rem <= {r_rem[tamanyo-2:0], r_quo[tamanyo-1]};
        end else begin
          r_rem <= w_trial[tamanyo-1:0];
        end
      end
      if (w_fix) begin
        COC <= r_sq   ? -r_quo : r_quo;
        RES <= r_snum ? -r_rem : r_rem;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divisor_algoritmico.sv
`default_nettype none
// ============================================================================
// Module   : tb_divisor_algoritmico
// Brief    : Self-checking bench for divisor_algoritmico against a C-style
//            truncating-division reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divisor_algoritmico;

  localparam int W = 32;

  logic         CLK;
  logic         RSTn;
  logic         START;
  logic [W-1:0] NUM;
  logic [W-1:0] DEN;
  logic [W-1:0] COC;
  logic [W-1:0] RES;
  logic         DONE;

  int errors = 0;
  int checks = 0;

  divisor_algoritmico #(.tamanyo(W)) dut (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .START (START),
    .NUM   (NUM),
    .DEN   (DEN),
    .COC   (COC),
    .RES   (RES),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: signed 64-bit division truncates toward zero, % follows NUM.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] n, input logic [W-1:0] d);
    longint sn, sd, q, r;
    logic [W-1:0] qq, rr;
    sn = longint'($signed(n));
    sd = longint'($signed(d));
    if (sd == 0) begin
      qq = n[W-1] ? W'(1) : '1;
      rr = n;
    end else begin
      q  = sn / sd;
      r  = sn % sd;
      qq = q[W-1:0];
      rr = r[W-1:0];
    end
    return {qq, rr};
  endfunction

  // Edges after the START-sampling edge until DONE is visible.
  function automatic int exp_lat(input logic [W-1:0] d);
`ifdef DIV_ZERO_FAST_EN
    if (d == '0) return 1;
`endif
    return W + 1;
  endfunction

  task automatic run_div(input logic [W-1:0] n, input logic [W-1:0] d,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output int lat, output bit held);
    logic [W-1:0] pq, pr;
    pq = COC; pr = RES; held = 1'b1;
    NUM = n; DEN = d; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    NUM = $urandom; DEN = $urandom;
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
      if (!DONE && (COC !== pq || RES !== pr)) held = 1'b0;
    end while (!DONE && lat < 100);
    q = COC; r = RES;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; START = 1'b0; NUM = '0; DEN = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (COC !== '0) begin errors++; $display("FAIL reset_coc: got %h expected 0", COC); end
    checks++; if (RES !== '0) begin errors++; $display("FAIL reset_res: got %h expected 0", RES); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
    RSTn = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] tn [11] = '{32'd4, 32'd4, -32'sd4, -32'sd4, 32'd7, -32'sd7, 32'd3,
                              32'h80000000, 32'h80000000, 32'd9, -32'sd9};
    logic [W-1:0] td [11] = '{32'd2, -32'sd2, 32'd2, -32'sd2, -32'sd2, 32'd2, 32'd5,
                              32'hFFFFFFFF, 32'd1, 32'd0, 32'd0};
    logic [W-1:0] eq [11] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd2, -32'sd3, -32'sd3, 32'd0,
                              32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'd1};
    logic [W-1:0] er [11] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd3,
                              32'd0, 32'd0, 32'd9, -32'sd9};
    logic [W-1:0] q, r;
    int lat;
    bit held;
    for (int i = 0; i < 11; i++) begin
      run_div(tn[i], td[i], q, r, lat, held);
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL dir_coc[%0d]: got %h expected %h", i, q, eq[i]); end
      checks++; if (r !== er[i]) begin errors++; $display("FAIL dir_res[%0d]: got %h expected %h", i, r, er[i]); end
      checks++; if (lat != exp_lat(td[i])) begin errors++; $display("FAIL dir_lat[%0d]: got %0d expected %0d", i, lat, exp_lat(td[i])); end
      checks++; if (!held) begin errors++; $display("FAIL dir_hold[%0d]: outputs changed before DONE", i); end
      @(posedge CLK); #1;
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL dir_done_drop[%0d]: got %b expected 0", i, DONE); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] n, d, q, r;
    logic [2*W-1:0] m;
    int lat;
    bit held;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       d = $urandom;
        1:       d = W'($signed($urandom_range(0, 40)) - 20);
        2:       d = '0;
        3:       d = '1;
        4:       d = 32'h80000000;
        default: d = $urandom >> $urandom_range(0, 30);
      endcase
      case ($urandom_range(0, 3))
        0:       n = 32'h80000000;
        1:       n = W'($signed($urandom_range(0, 200)) - 100);
        default: n = $urandom;
      endcase
      m = model(n, d);
      run_div(n, d, q, r, lat, held);
      checks++; if (q !== m[2*W-1:W]) begin errors++; $display("FAIL rnd_coc %h/%h: got %h expected %h", n, d, q, m[2*W-1:W]); end
      checks++; if (r !== m[W-1:0]) begin errors++; $display("FAIL rnd_res %h/%h: got %h expected %h", n, d, r, m[W-1:0]); end
      checks++; if (lat != exp_lat(d)) begin errors++; $display("FAIL rnd_lat %h/%h: got %0d expected %0d", n, d, lat, exp_lat(d)); end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int extra;
    NUM = 32'd1000; DEN = 32'd3; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    NUM = 32'd50; DEN = 32'd7; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = 11;
    while (!DONE && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
    end
    checks++; if (lat != W + 1) begin errors++; $display("FAIL ign_lat: got %0d expected %0d", lat, W + 1); end
    checks++; if (COC !== 32'd333) begin errors++; $display("FAIL ign_coc: got %h expected %h", COC, 32'd333); end
    checks++; if (RES !== 32'd1) begin errors++; $display("FAIL ign_res: got %h expected 1", RES); end
    extra = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ign_requeue: got %0d extra DONE expected 0", extra); end
  endtask

  task automatic test_reset_abort();
    int seen;
    logic [W-1:0] q, r;
    int lat;
    bit held;
    NUM = 32'd77; DEN = 32'd5; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    RSTn = 1'b0;
    #1;
    checks++; if (COC !== '0) begin errors++; $display("FAIL abort_coc: got %h expected 0", COC); end
    checks++; if (RES !== '0) begin errors++; $display("FAIL abort_res: got %h expected 0", RES); end
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_done: got %0d DONE pulses expected 0", seen); end
    run_div(-32'sd100, 32'd7, q, r, lat, held);
    checks++; if (q !== -32'sd14) begin errors++; $display("FAIL fresh_coc: got %h expected %h", q, -32'sd14); end
    checks++; if (r !== -32'sd2) begin errors++; $display("FAIL fresh_res: got %h expected %h", r, -32'sd2); end
    checks++; if (lat != W + 1) begin errors++; $display("FAIL fresh_lat: got %0d expected %0d", lat, W + 1); end
  endtask

  task automatic test_back_to_back();
    int lat;
    NUM = 32'd100; DEN = -32'sd9; START = 1'b1;
    @(posedge CLK); #1;
    lat = 0;
    while (!DONE && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
    end
    checks++; if (lat != W + 1) begin errors++; $display("FAIL b2b_lat1: got %0d expected %0d", lat, W + 1); end
    checks++; if (COC !== -32'sd11) begin errors++; $display("FAIL b2b_coc1: got %h expected %h", COC, -32'sd11); end
    checks++; if (RES !== 32'd1) begin errors++; $display("FAIL b2b_res1: got %h expected 1", RES); end
    // START still high: the next edge relaunches with these operands.
    NUM = -32'sd55; DEN = 32'd4;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = 0;
    while (!DONE && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
    end
    checks++; if (lat != W + 1) begin errors++; $display("FAIL b2b_lat2: got %0d expected %0d", lat, W + 1); end
    checks++; if (COC !== -32'sd13) begin errors++; $display("FAIL b2b_coc2: got %h expected %h", COC, -32'sd13); end
    checks++; if (RES !== -32'sd3) begin errors++; $display("FAIL b2b_res2: got %h expected %h", RES, -32'sd3); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
